bpsk_demodulator: RTL and testbench

- Receive-side counterpart of the BPSK modulator's sine/neg-sine generator.
- Takes offset-binary ADC-style samples, one symbol per SAMPLE_NUMBER samples, and correlates each symbol against the sign of the reference sine (sign correlator).
- Emits one hard bit per symbol plus a low-confidence flag.
- Sits between the sample source (loopback from the modulator, or ADC) and the bit sink / deframer.

---
 rtl/bpsk_pkg.sv | 41 ++++
 rtl/bpsk_sign_correlator.sv | 61 ++++++
 rtl/bpsk_demodulator.sv | 148 ++++++++++++++
 tb/tb_bpsk_demodulator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// -----------------------------------------------------------------------------
// bpsk_pkg
// Shared definitions for the BPSK modulator / demodulator pair.
//   - SAMPLE_MID / sample_mid(): offset-binary midpoint of the sample format
//   - acc_width(): signed width of the symbol correlator accumulator
//   - BIT_SINE / BIT_NEG_SINE: bit <-> waveform mapping shared with the modulator
//   - state_e: demodulator symbol FSM states
//   - corr_op_e: per-cycle command to the sign correlator
// -----------------------------------------------------------------------------
package bpsk_pkg;

    localparam int SAMPLE_WIDTH_DEFAULT = 12;
    localparam int SAMPLE_MID           = 1 << (SAMPLE_WIDTH_DEFAULT - 1);

    // Bit 0 is sent as the in-phase sine, bit 1 as the inverted sine.
    localparam logic BIT_SINE     = 1'b0;
    localparam logic BIT_NEG_SINE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CORR_HOLD  = 2'd0,  // keep accumulator
        CORR_CLEAR = 2'd1,  // force accumulator to zero
        CORR_LOAD  = 2'd2,  // start a new symbol: acc = +/-s
        CORR_ACC   = 2'd3   // acc = acc +/- s
    } corr_op_e;

    function automatic int sample_mid(input int sample_width);
        return 1 << (sample_width - 1);
    endfunction

    // One extra bit over the worst-case magnitude sum keeps the sign bit free,
    // so accumulating a whole symbol can never overflow.
    function automatic int acc_width(input int sample_width, input int sample_number);
        return sample_width + $clog2(sample_number) + 1;
    endfunction

endpackage

// File: rtl/bpsk_sign_correlator.sv
// -----------------------------------------------------------------------------
// bpsk_sign_correlator
// Centres an offset-binary sample and accumulates it against the sign of the
// reference sine.
// Ports:
//   clk, rst_n   clock / async active-low reset (accumulator -> 0)
//   op_i         command for this cycle (hold / clear / load / accumulate)
//   neg_i        reference sign is negative for this sample
//   sample_i     offset-binary sample
//   final_o      acc + (+/-s): value the accumulator would hold including
//                the current sample (used for the end-of-symbol decision)
// -----------------------------------------------------------------------------
module bpsk_sign_correlator
    import bpsk_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = 12,
    parameter int SAMPLE_NUMBER = 256,
    localparam int ACC_W        = acc_width(SAMPLE_WIDTH, SAMPLE_NUMBER)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  corr_op_e                op_i,
    input  logic                    neg_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    output logic signed [ACC_W-1:0] final_o
);

    localparam logic [SAMPLE_WIDTH:0] MID_W = (SAMPLE_WIDTH + 1)'(sample_mid(SAMPLE_WIDTH));

    logic signed [SAMPLE_WIDTH:0] centred;
    logic signed [SAMPLE_WIDTH:0] term;
    logic signed [ACC_W-1:0]      term_ext;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      acc_d;

    always_comb begin
        // One extra bit holds the full range -2^(W-1) .. 2^(W-1)-1 and its
        // negation (+2^(W-1)) without wrap.
        centred  = signed'({1'b0, sample_i} - MID_W);
        term     = neg_i ? -centred : centred;
        term_ext = {{(ACC_W - SAMPLE_WIDTH - 1){term[SAMPLE_WIDTH]}}, term};
        final_o  = acc_q + term_ext;

        acc_d = acc_q;
        case (op_i)
            CORR_CLEAR: acc_d = '0;
            CORR_LOAD:  acc_d = term_ext;
            CORR_ACC:   acc_d = final_o;
            default:    acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/bpsk_demodulator.sv
// -----------------------------------------------------------------------------
// bpsk_demodulator
// Sign-correlating BPSK demodulator: one hard bit per SAMPLE_NUMBER samples,
// correlated against the sign of one sine period.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   en             enable; low returns the FSM to IDLE
//   sync           symbol-start marker (qualified by sample_valid)
//   sample_valid   sample_in is valid this cycle
//   sample_in      offset-binary sample
//   bit_out        decided bit (0 = sine, 1 = inverted sine)
//   bit_valid      one-cycle strobe: bit_out / low_conf updated
//   low_conf       |correlation| below THRESHOLD for the decided symbol
//   signal_cnt     sample index within the current symbol
//   bit_cnt        number of decided bits (wraps)
// -----------------------------------------------------------------------------
module bpsk_demodulator
    import bpsk_pkg::*;
#(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12,
    parameter int THRESHOLD     = 4096,
    localparam int CNT_W        = $clog2(SAMPLE_NUMBER)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sync,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic                    low_conf,
    output logic [CNT_W-1:0]        signal_cnt,
    output logic [15:0]             bit_cnt
);

    localparam int ACC_W                 = acc_width(SAMPLE_WIDTH, SAMPLE_NUMBER);
    localparam logic [CNT_W-1:0] LAST_IX = CNT_W'(SAMPLE_NUMBER - 1);
    localparam logic [ACC_W-1:0] THR_W   = ACC_W'(THRESHOLD);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       bit_cnt_q, bit_cnt_d;
    logic              bit_out_q, bit_out_d;
    logic              low_conf_q, low_conf_d;
    logic              bit_valid_q, bit_valid_d;

    corr_op_e                corr_op;
    logic                    corr_neg;
    logic signed [ACC_W-1:0] corr_final;
    logic        [ACC_W-1:0] final_abs;

    bpsk_sign_correlator #(
        .SAMPLE_WIDTH  (SAMPLE_WIDTH),
        .SAMPLE_NUMBER (SAMPLE_NUMBER)
    ) u_corr (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_i     (corr_op),
        .neg_i    (corr_neg),
        .sample_i (sample_in),
        .final_o  (corr_final)
    );

    // Magnitude cannot overflow: the accumulator has a spare sign bit.
    assign final_abs = corr_final[ACC_W-1] ? ACC_W'(-corr_final) : ACC_W'(corr_final);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bit_out_d   = bit_out_q;
        low_conf_d  = low_conf_q;
        bit_valid_d = 1'b0;
        corr_op     = CORR_HOLD;
        // Second half of the sine period has negative reference sign.
        corr_neg    = cnt_q[CNT_W-1];

        case (state_q)
            IDLE: begin
                corr_op = CORR_CLEAR;
                cnt_d   = '0;
                if (en && sample_valid && sync) begin
                    state_d  = RUN;
                    corr_op  = CORR_LOAD;
                    corr_neg = 1'b0;
                    cnt_d    = CNT_W'(1);
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    corr_op = CORR_CLEAR;
                    cnt_d   = '0;
                end else if (sample_valid) begin
                    if (sync) begin
                        // Re-sync wins over everything, including the
                        // decision on the last index: partial symbol dropped.
                        corr_op  = CORR_LOAD;
                        corr_neg = 1'b0;
                        cnt_d    = CNT_W'(1);
                    end else if (cnt_q == LAST_IX) begin
                        bit_out_d   = corr_final[ACC_W-1] ? BIT_NEG_SINE : BIT_SINE;
                        low_conf_d  = (final_abs < THR_W);
                        bit_valid_d = 1'b1;
                        bit_cnt_d   = bit_cnt_q + 16'd1;
                        corr_op     = CORR_CLEAR;
                        cnt_d       = '0;
                    end else begin
                        corr_op = CORR_ACC;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                corr_op = CORR_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            bit_out_q   <= 1'b0;
            low_conf_q  <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_out_q   <= bit_out_d;
            low_conf_q  <= low_conf_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign low_conf   = low_conf_q;
    assign signal_cnt = cnt_q;
    assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// -----------------------------------------------------------------------------
// tb_bpsk_demodulator
// Directed bench for bpsk_demodulator at default parameters. Expected
// decisions come from a reference correlation model and are queued when the
// last sample of a symbol is driven; a monitor pops them on each bit_valid.
// -----------------------------------------------------------------------------
module tb_bpsk_demodulator;

    localparam int N   = 256;
    localparam int W   = 12;
    localparam int MID = 2048;
    localparam int THR = 4096;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sync;
    logic        sample_valid;
    logic [W-1:0] sample_in;
    logic        bit_out;
    logic        bit_valid;
    logic        low_conf;
    logic [7:0]  signal_cnt;
    logic [15:0] bit_cnt;

    typedef struct packed {
        logic        b;
        logic        lc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic        last_bit = 1'b0;
    logic        prev_valid = 1'b0;
    int          sym[N];

    bpsk_demodulator #(
        .SAMPLE_NUMBER (N),
        .SAMPLE_WIDTH  (W),
        .THRESHOLD     (THR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sync         (sync),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .low_conf     (low_conf),
        .signal_cnt   (signal_cnt),
        .bit_cnt      (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued decision.
    always @(negedge clk) begin
        if (bit_valid === 1'b1) begin
            chk("bit_valid_back_to_back", {31'b0, prev_valid}, 0);
            if (sb.size() == 0) begin
                chk("bit_valid_unexpected", {31'b0, bit_valid}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bit_out", {31'b0, bit_out}, {31'b0, e.b});
                chk("low_conf", {31'b0, low_conf}, {31'b0, e.lc});
                chk("bit_cnt_at_strobe", {16'b0, bit_cnt}, {16'b0, e.cnt});
            end
        end
        prev_valid = bit_valid;
    end

    task automatic step(input logic v, input logic sy, input int smp);
        logic [31:0] s32;
        s32          = smp;
        sample_valid = v;
        sync         = sy;
        sample_in    = s32[W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic fill_square(input int first, input int second);
        for (int i = 0; i < N; i++) sym[i] = (i < N/2) ? first : second;
    endtask

    // Full symbol from sym[], sync on index 0; optional idle cycle after each sample.
    task automatic send_symbol(input bit gaps);
        int   acc;
        exp_t e;
        acc = 0;
        for (int i = 0; i < N; i++)
            acc += (i < N/2) ? (sym[i] - MID) : (MID - sym[i]);
        e.b   = (acc < 0);
        e.lc  = (acc < THR) && (acc > -THR);
        e.cnt = exp_cnt + 16'd1;
        for (int i = 0; i < N; i++) begin
            if (i == N-1) begin
                sb.push_back(e);
                exp_cnt  = exp_cnt + 16'd1;
                last_bit = e.b;
            end
            step(1'b1, i == 0, sym[i]);
            if (i == 0)   chk("signal_cnt_after_sync", {24'b0, signal_cnt}, 1);
            if (i == N-1) begin
                chk("bit_valid_latency", {31'b0, bit_valid}, 1);
                chk("signal_cnt_wrap", {24'b0, signal_cnt}, 0);
            end
            if (gaps) begin
                step(1'b0, 1'b0, MID);
                if (i == 10) chk("signal_cnt_hold_on_gap", {24'b0, signal_cnt}, 11);
                if (i == N-1) chk("bit_valid_single_cycle", {31'b0, bit_valid}, 0);
            end
        end
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) step(1'b1, i == 0, sym[i]);
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = 1'b0;
        sync         = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bit_out", {31'b0, bit_out}, 0);
        chk("reset_bit_valid", {31'b0, bit_valid}, 0);
        chk("reset_low_conf", {31'b0, low_conf}, 0);
        chk("reset_signal_cnt", {24'b0, signal_cnt}, 0);
        chk("reset_bit_cnt", {16'b0, bit_cnt}, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        step(1'b0, 1'b0, MID);

        // Square wave, then inverted square wave.
        fill_square(3048, 1048);
        send_symbol(1'b0);
        step(1'b0, 1'b0, MID);
        chk("bit_cnt_after_first", {16'b0, bit_cnt}, 1);
        fill_square(1048, 3048);
        send_symbol(1'b0);

        // Modulator sine then negated sine.
        for (int i = 0; i < N; i++)
            sym[i] = MID + $rtoi($floor(1000.0 * $sin(2.0 * 3.14159265358979 * i / N) + 0.5));
        send_symbol(1'b0);
        for (int i = 0; i < N; i++) sym[i] = 2 * MID - sym[i];
        send_symbol(1'b0);

        // Zero-energy and weak symbols: low confidence.
        fill_square(MID, MID);
        send_symbol(1'b0);
        fill_square(MID + 10, MID - 10);
        send_symbol(1'b0);

        // Valid every other cycle.
        fill_square(3048, 1048);
        send_symbol(1'b1);

        // Re-sync at index 100, then at the last index.
        send_partial(100);
        send_symbol(1'b0);
        send_partial(N-1);
        send_symbol(1'b0);

        // Disable at index 50.
        fill_square(1048, 3048);
        send_partial(50);
        en = 1'b0;
        step(1'b1, 1'b0, 1048);
        chk("disable_signal_cnt", {24'b0, signal_cnt}, 0);
        chk("disable_bit_cnt", {16'b0, bit_cnt}, {16'b0, exp_cnt});
        chk("disable_bit_out_hold", {31'b0, bit_out}, {31'b0, last_bit});
        step(1'b1, 1'b0, 1048);
        chk("idle_ignores_samples", {24'b0, signal_cnt}, 0);
        en = 1'b1;
        send_symbol(1'b0);

        // Asynchronous reset mid-symbol.
        send_partial(200);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bit_out", {31'b0, bit_out}, 0);
        chk("async_rst_signal_cnt", {24'b0, signal_cnt}, 0);
        chk("async_rst_bit_cnt", {16'b0, bit_cnt}, 0);
        chk("async_rst_low_conf", {31'b0, low_conf}, 0);
        chk("async_rst_bit_valid", {31'b0, bit_valid}, 0);
        exp_cnt = 16'd0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 2 * N; i++) step(1'b1, 1'b0, sym[i % N]);
        chk("no_sync_signal_cnt", {24'b0, signal_cnt}, 0);
        chk("no_sync_bit_cnt", {16'b0, bit_cnt}, 0);
        fill_square(3048, 1048);
        send_symbol(1'b0);

        step(1'b0, 1'b0, MID);
        step(1'b0, 1'b0, MID);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
